// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: shares one Avalon-MM slave port between instruction-fetch and data masters.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed data-first priority.
module mips_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_address,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata,
    output logic [1:0]  owner,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        dsel_q, dsel_d;
    logic [15:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic        d_req, d_wins, pick_d, cur_req;
    logic        gnt_i, gnt_d, abort_i, abort_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic        rr_data_q, rr_data_d;
    assign d_wins = ~rr_data_q;
`else
    assign d_wins = 1'b1;
`endif

    assign d_req   = d_read | d_write;
    assign pick_d  = d_req & (~i_read | d_wins);
    assign cur_req = dsel_q ? d_req : i_read;

    always_comb begin
        state_d = state_q;
        dsel_d  = dsel_q;
        wd_d    = wd_q;
        err_d   = err_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_data_d = rr_data_q;
`endif
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (d_req | i_read) begin
                    state_d = pick_d ? GNT_D : GNT_I;
                    dsel_d  = pick_d;
                end
            end
            GNT_I, GNT_D: begin
                if (!cur_req) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_data_d = dsel_q;
`endif
                end else begin
                    // Watchdog fires on the TIMEOUT_CYCLES-th stalled granted cycle
                    wd_d = wd_q + 16'd1;
                    if (wd_q == WD_LAST) begin
                        state_d = ABORT;
                        err_d   = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_data_d = dsel_q;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dsel_q  <= 1'b0;
            wd_q    <= '0;
            err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_data_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dsel_q  <= dsel_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_data_q <= rr_data_d;
`endif
        end
    end

    // Routing is purely combinational on state so reset drops strobes at once
    assign gnt_i   = state_q == GNT_I;
    assign gnt_d   = state_q == GNT_D;
    assign abort_i = (state_q == ABORT) & ~dsel_q;
    assign abort_d = (state_q == ABORT) & dsel_q;

    assign s_read        = gnt_i ? i_read : gnt_d & d_read;
    assign s_write       = gnt_d & d_write;
    assign s_address     = gnt_i ? i_address : gnt_d ? d_address : '0;
    assign s_writedata   = gnt_d ? d_writedata : '0;
    assign s_byteenable  = gnt_i ? 4'hF : gnt_d ? d_byteenable : '0;
    assign i_waitrequest = gnt_i ? s_waitrequest : ~abort_i;
    assign d_waitrequest = gnt_d ? s_waitrequest : ~abort_d;
    assign i_readdata    = gnt_i ? s_readdata : '0;
    assign d_readdata    = gnt_d ? s_readdata : '0;
    assign owner         = state_q == IDLE ? 2'b00 : dsel_q ? 2'b10 : 2'b01;
    assign timeout_err   = err_q;
endmodule
